// File: rtl/async_fifo_pkg.sv
// Shared Gray-code helpers for both controllers of the dual-clock FIFO.
// Functions take zero-extended pointers, so one definition serves every pointer width.
package async_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int PTR_W          = DEF_ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// Synchronous active-low reset clears every stage.
module gray_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: pointer, empty, sticky underflow,
// and (with macro RD_CTRL_LEVEL_EN defined) occupancy level and almost-empty.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                  rclock,
  input  logic                  rreset,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH:0]   gray_wptr_async,
  output logic                  rd_fire,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   gray_rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int PTR_BITS = ADDR_WIDTH + 1;

  logic [PTR_BITS-1:0] wptr_sync;
  logic [PTR_BITS-1:0] bin_rptr;
  logic [PTR_BITS-1:0] bin_next;
  logic [PTR_BITS-1:0] gray_next;

  gray_ptr_sync #(
    .WIDTH  (PTR_BITS),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clock (rclock),
    .reset (rreset),
    .d     (gray_wptr_async),
    .q     (wptr_sync)
  );

  assign rd_fire   = r_en & ~empty;
  assign raddr     = bin_rptr[ADDR_WIDTH-1:0];
  assign bin_next  = bin_rptr + PTR_BITS'(rd_fire);
  assign gray_next = PTR_BITS'(bin2gray(32'(bin_next)));

  // Empty compares against the post-read pointer so the last read flags empty on its own edge.
  always_ff @(posedge rclock) begin
    if (!rreset) begin
      bin_rptr  <= '0;
      gray_rptr <= '0;
      empty     <= 1'b1;
      underflow <= 1'b0;
    end else begin
      bin_rptr  <= bin_next;
      gray_rptr <= gray_next;
      empty     <= (gray_next == wptr_sync);
      if (r_en && empty) underflow <= 1'b1;
    end
  end

`ifdef RD_CTRL_LEVEL_EN
  localparam logic [PTR_BITS-1:0] AE_LIM = PTR_BITS'(AE_THRESH);

  logic [PTR_BITS-1:0] wbin;
  logic [PTR_BITS-1:0] level_next;

  // Delayed write pointer makes this level pessimistic, never optimistic.
  assign wbin       = PTR_BITS'(gray2bin(32'(wptr_sync)));
  assign level_next = wbin - bin_next;

  always_ff @(posedge rclock) begin
    if (!rreset) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_LIM);
    end
  end
`else
  assign rd_level     = '0;
  assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomised bench for async_fifo_rd_ctrl against a write-count / read-count occupancy model.
module tb_async_fifo_rd_ctrl;

  localparam int AW   = 3;
  localparam int SYNC = 2;
  localparam int AE   = 1;

  logic          rclock = 1'b0;
  logic          rreset = 1'b0;
  logic          r_en   = 1'b0;
  logic [AW:0]   gray_wptr_async = '0;
  logic          rd_fire;
  logic [AW-1:0] raddr;
  logic [AW:0]   gray_rptr;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  async_fifo_rd_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SYNC),
    .AE_THRESH   (AE)
  ) dut (
    .rclock          (rclock),
    .rreset          (rreset),
    .r_en            (r_en),
    .gray_wptr_async (gray_wptr_async),
    .rd_fire         (rd_fire),
    .raddr           (raddr),
    .gray_rptr       (gray_rptr),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .rd_level        (rd_level),
    .underflow       (underflow)
  );

  always #5 rclock = ~rclock;

  int checks = 0;
  int errors = 0;

  // Model state: writes issued, reads done, and what the read side can see of the writes.
  logic [AW:0] wcnt = '0;
  logic [AW:0] m_r  = '0;
  logic [AW:0] hist [SYNC];
  logic [AW:0] m_lvl = '0;
  logic        m_empty = 1'b1;
  logic        m_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic en, input logic rst_n);
    logic [AW:0] wsync;
    logic        fire;
    logic [AW:0] exp_lvl;
    logic        exp_ae;
    @(negedge rclock);
    r_en = en;
    rreset = rst_n;
    gray_wptr_async = wcnt ^ (wcnt >> 1);
    #1;
    fire = en & ~m_empty;
    chk("rd_fire", 32'(rd_fire), 32'(fire));
    chk("raddr", 32'(raddr), 32'(m_r[AW-1:0]));
    @(posedge rclock);
    if (!rst_n) begin
      m_r = '0;
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
      m_empty = 1'b1;
      m_lvl = '0;
      m_uf = 1'b0;
    end else begin
      if (en && m_empty) m_uf = 1'b1;
      m_r = m_r + (AW+1)'(fire);
      wsync = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wcnt;
      m_lvl = wsync - m_r;
      m_empty = (m_lvl == 0);
    end
`ifdef RD_CTRL_LEVEL_EN
    exp_lvl = m_lvl;
    exp_ae  = (int'(m_lvl) <= AE);
`else
    exp_lvl = '0;
    exp_ae  = m_empty;
`endif
    #1;
    chk("empty", 32'(empty), 32'(m_empty));
    chk("gray_rptr", 32'(gray_rptr), 32'(m_r ^ (m_r >> 1)));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("rd_level", 32'(rd_level), 32'(exp_lvl));
    chk("almost_empty", 32'(almost_empty), 32'(exp_ae));
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) hist[i] = '0;

    // Reset held two edges
    wcnt = '0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_gray", 32'(gray_rptr), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);

    // Eight writes arrive at once; empty must drop exactly on the third edge
    wcnt = 4'd8;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("fill_empty_e2", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1);
    chk("fill_empty_e3", 32'(empty), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    chk("drain_gray", 32'(gray_rptr), 32'hC);
    chk("drain_empty", 32'(empty), 32'd1);

    // Read while empty sets sticky underflow
    cycle(1'b1, 1'b1);
    chk("uf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    chk("uf_sticky", 32'(underflow), 32'd1);
    chk("uf_gray_hold", 32'(gray_rptr), 32'hC);
    wcnt = '0;
    cycle(1'b0, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);

    // Random traffic with pointer wraps and occasional mid-operation reset
    for (int n = 0; n < 4000; n++) begin
      logic en;
      logic rst_n;
      en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 249) != 0);
      if (!rst_n) begin
        wcnt = (AW+1)'($urandom_range(0, 8));
      end else if ($urandom_range(0, 1) == 1 && ((wcnt - m_r) & 4'hF) < 8) begin
        wcnt = wcnt + 1'b1;
      end
      cycle(en, rst_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
